// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder datapath.
//   NIBBLE_W : width of one adder stage (one nibble)
//   state_t  : control FSM state encoding
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : adder_pkg

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple-carry adder stage.
// Ports:
//   a, b    : nibble operands
//   cin     : carry in
//   sum_c   : nibble sum
//   cout_c  : carry out of bit 3
module four_bit_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum_c,
  output logic                cout_c
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum_c[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout_c = carry[NIBBLE_W];

endmodule : four_bit_adder

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder/subtractor: one nibble per cycle through a single
// 4-bit adder stage, LSB first, carry chained through a register.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   in_a, in_b, in_sub   : operands; in_sub=1 computes A-B as A+~B+1
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   out_sum              : W-bit result modulo 2^W
//   out_cout             : carry out of bit W-1 (subtract: 1 = no borrow)
//   out_ovf              : signed overflow
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                      in_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                      out_cout,
  output logic                      out_ovf
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               carry_q;
  logic               a_msb_q;
  logic               b_msb_q;
  logic [IDX_W-1:0]   idx_q;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  // Per-nibble datapath: always looks at the low nibble of the shifting operands.
  four_bit_adder u_adder (
    .a      (a_q[NIBBLE_W-1:0]),
    .b      (b_q[NIBBLE_W-1:0]),
    .cin    (carry_q),
    .sum_c  (nib_sum),
    .cout_c (nib_cout)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_sub ? ~in_b : in_b;
            carry_q  <= in_sub;
            a_msb_q  <= in_a[W-1];
            b_msb_q  <= in_b[W-1] ^ in_sub;
            idx_q    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          // Sum nibbles enter at the top so the LSB nibble lands at bit 0 last.
          out_sum <= (out_sum >> NIBBLE_W) | (W'(nib_sum) << (W - NIBBLE_W));
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          carry_q <= nib_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            out_cout  <= nib_cout;
            // nib_sum[3] is the final result MSB on the last nibble.
            out_ovf   <= (a_msb_q == b_msb_q) && (nib_sum[NIBBLE_W-1] != a_msb_q);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4, W=16).
module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 16;
  localparam int          LAT     = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on the mathematical values of the operands.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
    int ua, ub, sa, sb, full, sres;
    logic [15:0] s;
    logic c, o;
    ua   = int'(a);
    ub   = int'(b);
    sa   = (ua >= 32768) ? ua - 65536 : ua;
    sb   = (ub >= 32768) ? ub - 65536 : ub;
    full = sub ? ua - ub : ua + ub;
    s    = 16'(full);
    c    = sub ? (ua >= ub) : (full >= 65536);
    sres = sub ? sa - sb : sa + sb;
    o    = (sres > 32767) || (sres < -32768);
    return {o, c, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for the result (bounded), then consume it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output logic [15:0] s, output logic c,
                        output logic o);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    s = out_sum; c = out_cout; o = out_ovf;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b o=%b, want rdy=1 vld=0 sum=0000 c=0 o=0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rdy=%b vld=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      int lat; logic [15:0] s; logic c, o;
      run_op(va[i], vb[i], vs[i], lat, s, c, o);
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed%0d_latency: got %0d cycles, want %0d", i, lat, LAT);
      end
      n_checks++;
      if ({s, c, o} !== {es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL directed%0d_result: sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed%0d_ready_after: in_ready=%b, want 1", i, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] s; logic c, o;
    in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    // Hold the result while a competing operand is offered.
    in_a = 16'hAAAA; in_b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: vld=%b rdy=%b sum=%h c=%b o=%b, want 1 0 3333 0 0",
                 i, out_valid, in_ready, out_sum, out_cout, out_ovf);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b vld=%b, want 1/0", in_ready, out_valid);
    end
    run_op(16'h0100, 16'h0200, 1'b0, lat, s, c, o);
    n_checks++;
    if ({s, c, o} !== {16'h0300, 1'b0, 1'b0} || lat !== LAT) begin
      n_fail++;
      $display("FAIL backpressure_next: sum=%h c=%b o=%b lat=%0d, want 0300 0 0 lat=%0d",
               s, c, o, lat, LAT);
    end
  endtask

  task automatic test_rst_mid();
    int lat; logic [15:0] s; logic c, o;
    logic seen_valid;
    seen_valid = 1'b0;
    in_a = 16'h1234; in_b = 16'h1111; in_sub = 1'b0; in_valid = 1'b1;
    step();                 // accept edge
    in_valid = 1'b0;
    step();                 // first BUSY cycle done; now in second BUSY cycle
    seen_valid |= out_valid;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_sum !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: rdy=%b sum=%h vld=%b, want 1 0000 0",
               in_ready, out_sum, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      seen_valid |= out_valid;
      step();
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_result: out_valid seen=%b, want 0", seen_valid);
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat, s, c, o);
    n_checks++;
    if ({s, c, o} !== {16'h0002, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_recover: sum=%h c=%b o=%b, want 0002 0 0", s, c, o);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra [3];
    logic [15:0] rb [3];
    logic        rs [3];
    int acc_cyc [3];
    int issued, done_cnt;
    for (int i = 0; i < 3; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom);
    end
    issued = 0;
    done_cnt = 0;
    in_a = ra[0]; in_b = rb[0]; in_sub = rs[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && done_cnt < 3; cyc++) begin
      if (out_valid) begin
        logic [17:0] exp;
        exp = ref_model(ra[done_cnt], rb[done_cnt], rs[done_cnt]);
        n_checks++;
        if ({out_ovf, out_cout, out_sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b%0d_result: %h %s %h -> sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                   done_cnt, ra[done_cnt], rs[done_cnt] ? "-" : "+", rb[done_cnt],
                   out_sum, out_cout, out_ovf, exp[15:0], exp[16], exp[17]);
        end
        done_cnt++;
      end
      if (in_ready && in_valid) begin
        acc_cyc[issued] = cyc;
        issued++;
      end
      step();
      if (issued < 3) begin
        in_a = ra[issued]; in_b = rb[issued]; in_sub = rs[issued];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (done_cnt !== 3 || issued !== 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: completed=%0d issued=%0d, want 3/3", done_cnt, issued);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== NIBBLES + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: %0d cycles, want %0d",
                   i, acc_cyc[i] - acc_cyc[i-1], NIBBLES + 2);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder/subtractor that computes a W-bit sum by driving one 4-bit ripple-carry adder stage with one nibble per cycle, least significant first, and chaining the carry through a register. Sits directly upstream of the 4-bit adder and consumes its sum/carry each cycle. Presents valid/ready handshakes on both the operand side and the result side, so it drops into the datapath between an operand source and a result sink.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts operands; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  0: A+B; 1: A−B, computed as A + ~B + 1.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  sink accepts result.
- out_sum  out  W  result, two's complement modulo 2^W.
- out_cout  out  1  carry out of bit W−1; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  out  1  signed overflow.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B_eff = in_sub ? ~in_b : in_b, and carry = in_sub.
  - Record a_msb = in_a[W−1] and b_msb = B_eff[W−1]; clear nibble index; go to BUSY.
- BUSY, one cycle per nibble:
  - Adder inputs: A[3:0], B_eff[3:0], carry.
  - Shift the adder sum nibble into the sum register from the top; shift A and B_eff right by 4.
  - carry <= adder cout; index++.
  - After the cycle with index == NIBBLES−1: go to DONE. out_cout = final carry.
- out_ovf = (a_msb == b_msb) && (sum[W−1] != a_msb).
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf hold stable while out_ready=0.
  - On out_ready: go to IDLE.
- in_valid while not in IDLE: ignored; operands are not sampled.
- out_ready while not in DONE: ignored.
- No pipelining: one operation in flight at a time.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, index=0, carry=0.
- Accept at edge E0 → BUSY for NIBBLES cycles → out_valid first high in the cycle after edge E0+NIBBLES.
- Result-handshake edge Ed → in_ready=1 in the following cycle.
- Minimum issue interval: NIBBLES+2 cycles (accept, NIBBLES × BUSY, one DONE cycle).
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready.
- rst mid-operation (BUSY or DONE): operation is abandoned, no result is produced, and all reset values apply from the next cycle.
- NIBBLES=1: BUSY lasts exactly one cycle.
- Operand wrap-around: sum is modulo 2^W; carry out is reported only through out_cout.

## Structure
- Shared package adder_pkg:
  - NIBBLE_W = 4.
  - State enum typedef (IDLE/BUSY/DONE).
- Exactly one sub-module: four_bit_adder, instantiated once as the per-nibble datapath.
- Index counter width: $clog2(NIBBLES) with a minimum of 1.

## Test plan
- NIBBLES=4, A=0x1234, B=0x0FFF, sub=0 → out_sum=0x2233, cout=0, ovf=0; out_valid rises 4 cycles after the accept edge.
- A=0xFFFF, B=0x0001, sub=0 → 0x0000, cout=1, ovf=0. A=0x7FFF, B=0x0001 → 0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout.
  - New in_valid with A=0xAAAA in that window is not accepted.
  - After release, the next accepted operation completes correctly.
- Assert rst in the 2nd BUSY cycle → out_valid never rises for that operation; the cycle after rst deasserts shows in_ready=1, out_sum=0, and a new 0x0001+0x0001 yields 0x0002.
- Back-to-back: keep in_valid and out_ready high for 3 random operations → each result matches a reference model; accept edges are spaced exactly 6 cycles apart.
